// File: rtl/start_ctrl.sv
// Start-switch front end: syncs and debounces the raw start level, then runs
// the idle -> countdown -> run -> over sequence for the game core and display.
module start_ctrl #(
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int TICK_CYC     = 100000000,
  parameter int COUNT_SEC    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       game_over,
  output logic       running,
  output logic       start_pulse,
  output logic [3:0] countdown,
  output logic [1:0] state,
  output logic       led
);

  localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int TW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, COUNT = 2'd1, RUN = 2'd2, OVER = 2'd3} state_t;

  state_t          st, st_nxt;
  logic [1:0]      sync_pipe;
  logic            s_sync, level_db, level_q, rise, tick, tick_en;
  logic [DW-1:0]   db_cnt;
  logic [TW-1:0]   tick_cnt;
  logic [3:0]      cd_nxt;
  logic            led_nxt, pulse_nxt;

  assign s_sync  = sync_pipe[1];
  assign rise    = level_db & ~level_q;
  assign tick_en = (st == COUNT) || (st == OVER);
  assign tick    = tick_en && (tick_cnt == TW'(TICK_CYC - 1));
  assign state   = st;

  // Synchroniser and debounce; level_db only moves after DEBOUNCE_CYC stable cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_pipe <= '0;
      level_db  <= 1'b0;
      level_q   <= 1'b0;
      db_cnt    <= '0;
    end else begin
      sync_pipe <= {sync_pipe[0], start};
      level_q   <= level_db;
      if (s_sync == level_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DW'(DEBOUNCE_CYC - 1)) begin
        level_db <= s_sync;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // Tick counter restarts on every state change so each phase gets full ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tick_cnt <= '0;
    else if (st_nxt != st || !tick_en || tick)
      tick_cnt <= '0;
    else
      tick_cnt <= tick_cnt + 1'b1;
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st          <= IDLE;
      running     <= 1'b0;
      start_pulse <= 1'b0;
      countdown   <= '0;
      led         <= 1'b0;
    end else begin
      st          <= st_nxt;
      running     <= (st_nxt == RUN);
      start_pulse <= pulse_nxt;
      countdown   <= cd_nxt;
      led         <= led_nxt;
    end
  end

  always_comb begin
    st_nxt = st;
    case (st)
      IDLE:  if (rise) st_nxt = COUNT;
      COUNT: begin
        if (!level_db)                        st_nxt = IDLE;
        else if (tick && countdown == 4'd1)   st_nxt = RUN;
      end
      RUN: begin
        if (game_over)      st_nxt = OVER;
        else if (!level_db) st_nxt = IDLE;
      end
      OVER:  if (!level_db) st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  always_comb begin
    cd_nxt    = countdown;
    led_nxt   = led;
    pulse_nxt = 1'b0;
    case (st)
      IDLE: begin
        cd_nxt  = 4'd0;
        led_nxt = 1'b0;
        if (rise) begin
          cd_nxt  = 4'(COUNT_SEC);
          led_nxt = 1'b1;
        end
      end
      COUNT: begin
        if (!level_db) begin
          cd_nxt  = 4'd0;
          led_nxt = 1'b0;
        end else if (tick && countdown == 4'd1) begin
          cd_nxt    = 4'd0;
          led_nxt   = 1'b1;
          pulse_nxt = 1'b1;
        end else if (tick) begin
          cd_nxt  = countdown - 4'd1;
          led_nxt = ~led;
        end
      end
      RUN: begin
        cd_nxt  = 4'd0;
        led_nxt = 1'b1;
        // OVER blinks from dark; IDLE is dark too
        if (game_over || !level_db) led_nxt = 1'b0;
      end
      OVER: begin
        cd_nxt = 4'd0;
        if (!level_db)  led_nxt = 1'b0;
        else if (tick)  led_nxt = ~led;
      end
      default: begin
        cd_nxt  = 4'd0;
        led_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_start_ctrl.sv
// Directed bench for start_ctrl with short debounce/tick constants.
module tb_start_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       game_over;
  logic       running;
  logic       start_pulse;
  logic [3:0] countdown;
  logic [1:0] state;
  logic       led;

  int total = 0;
  int bad   = 0;

  start_ctrl #(.DEBOUNCE_CYC(4), .TICK_CYC(10), .COUNT_SEC(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .game_over(game_over),
    .running(running), .start_pulse(start_pulse), .countdown(countdown),
    .state(state), .led(led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; game_over = 1'b0;
    #2;
    chk("rst_state", state, 0);
    chk("rst_cd", countdown, 0);
    chk("rst_led", led, 0);
    chk("rst_run", running, 0);
    chk("rst_pulse", start_pulse, 0);
    step(2);
    rst_n = 1'b1;
    step(1);

    // clean start: cycle 0
    start = 1'b1;
    step(6);  chk("c6_idle", state, 0);
    step(1);  chk("c7_count", state, 1); chk("c7_cd", countdown, 3); chk("c7_led", led, 1);
    step(9);  chk("c16_cd", countdown, 3);
    step(1);  chk("c17_cd", countdown, 2); chk("c17_led", led, 0);
    step(10); chk("c27_cd", countdown, 1); chk("c27_led", led, 1);
    step(9);  chk("c36_count", state, 1); chk("c36_pulse", start_pulse, 0);
    step(1);  chk("c37_run", state, 2); chk("c37_pulse", start_pulse, 1);
              chk("c37_running", running, 1); chk("c37_led", led, 1); chk("c37_cd", countdown, 0);
    step(1);  chk("c38_pulse", start_pulse, 0); chk("c38_running", running, 1);

    // game over, then blink in OVER
    game_over = 1'b1;
    step(1);  game_over = 1'b0;
    chk("go_over", state, 3); chk("go_running", running, 0); chk("go_led", led, 0); chk("go_cd", countdown, 0);
    step(9);  chk("ov9_led", led, 0);
    step(1);  chk("ov10_led", led, 1);
    step(10); chk("ov20_led", led, 0);
    step(30); chk("ov50_state", state, 3);
    start = 1'b0;
    step(6);  chk("ovdrop6", state, 3);
    step(1);  chk("ovdrop7", state, 0); chk("ovdrop7_led", led, 0);

    // bounces of 3 cycles never pass the debouncer
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 6; c++) begin
        start = (c < 3);
        step(1);
        chk("bnc_state", state, 0); chk("bnc_cd", countdown, 0);
      end
    end
    start = 1'b0;
    step(6);  chk("bnc_end", state, 0);

    // re-arm, then abort at countdown 2
    start = 1'b1;
    step(6);  chk("rearm6", state, 0);
    step(1);  chk("rearm7", state, 1); chk("rearm_cd", countdown, 3);
    step(10); chk("ab_cd2", countdown, 2);
    start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      step(1);
      chk("ab_pulse", start_pulse, 0);
      if (c == 6) begin chk("ab6_state", state, 1); chk("ab6_cd", countdown, 2); end
    end
    chk("ab7_state", state, 0); chk("ab7_cd", countdown, 0); chk("ab7_led", led, 0);

    // game_over in the same cycle level_db falls
    start = 1'b1;
    step(7);  chk("sc_count", state, 1);
    step(30); chk("sc_run", state, 2);
    start = 1'b0;
    step(6);  chk("sc_run6", state, 2);
    game_over = 1'b1;
    step(1);  game_over = 1'b0;
    chk("sc_over", state, 3);
    step(1);  chk("sc_idle", state, 0);

    // async reset mid-countdown
    start = 1'b1;
    step(7);  chk("rs_count", state, 1);
    step(10); chk("rs_cd2", countdown, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("rs_state", state, 0); chk("rs_cd", countdown, 0);
    chk("rs_led", led, 0); chk("rs_running", running, 0);
    step(2);
    rst_n = 1'b1;
    step(6);  chk("rs_rel6", state, 0);
    step(1);  chk("rs_rel7", state, 1); chk("rs_rel7_cd", countdown, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
